// File: rtl/sub_serial4.sv
// Digit-serial unsigned subtractor: d = a - b - bin, one 4-bit digit per clock, LSB first.
// A registered borrow links successive digits; results hold until the next accepted start.

module sub_serial4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[4];
endmodule

module sub_serial4 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa, sb;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic [3:0]       nb, dig;
    logic             co;
    logic [WIDTH-1:0] dnext;

    // Subtract as a + ~b + ~borrow; the carry-out is the inverted borrow.
    assign nb    = ~sb[3:0];
    assign dnext = {dig, d[WIDTH-1:4]};

    sub_serial4_slice u_slice (
        .x    (sa[3:0]),
        .y    (nb),
        .cin  (~borrow),
        .s    (dig),
        .cout (co)
    );

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            sa     <= '0;
            sb     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    sa     <= {4'b0, sa[WIDTH-1:4]};
                    sb     <= {4'b0, sb[WIDTH-1:4]};
                    borrow <= ~co;
                    d      <= dnext;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_DONE;
                        bout  <= ~co;
                        zero  <= (dnext == '0);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_serial4.sv
// Self-checking bench for sub_serial4: table vectors, corner sequences and a
// random back-to-back run, all scored through an expected-result queue.

module tb_sub_serial4;
    localparam int W = 32;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         bin = 1'b0;
    logic         ready, done, bout, zero;
    logic [W-1:0] d;

    sub_serial4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .ready(ready), .done(done), .d(d), .bout(bout), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         zero;
        int           t;
    } exp_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic         bin;
        logic [W-1:0] d;
        logic         bout, zero;
    } vec_t;

    exp_t         q[$];
    int           ncmp = 0, nerr = 0;
    int           cyc = 0;
    logic         prev_done = 1'b0;
    logic [W-1:0] exp_d = '0;
    logic         exp_bout = 1'b0, exp_zero = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Acceptance pushes the expected result; done pops and compares.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && start && ready)
            q.push_back('{d: exp_d, bout: exp_bout, zero: exp_zero, t: cyc + 1});
    end

    always @(negedge clk) begin
        if (done) begin
            chk("done_pulse", {63'b0, prev_done}, 64'd0);
            if (q.size() == 0) begin
                chk("done_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("d", {32'b0, d}, {32'b0, e.d});
                chk("bout", {63'b0, bout}, {63'b0, e.bout});
                chk("zero", {63'b0, zero}, {63'b0, e.zero});
                chk("latency", 64'(cyc - e.t), 64'(N));
            end
        end
        prev_done <= done;
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic apply(input logic [W-1:0] va, vb, input logic vbin,
                         input logic [W-1:0] ed, input logic eb, ez);
        wait_ready();
        a = va; b = vb; bin = vbin;
        exp_d = ed; exp_bout = eb; exp_zero = ez;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        vec_t vt[8];
        logic [W:0] diff;
        logic [W-1:0] ra, rb;
        logic rbin;
        int t, tprev, n;

        vt[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0};
        vt[1] = '{32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
        vt[2] = '{32'h10000000, 32'h00000001, 1'b0, 32'h0FFFFFFF, 1'b0, 1'b0};
        vt[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[4] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[6] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b0, 1'b1};
        vt[7] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'h4B4B4B4B, 1'b0, 1'b0};

        // Reset state, checked while reset is held.
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'b0, ready}, 64'd1);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_d", {32'b0, d}, 64'd0);
        chk("rst_bout_zero", {62'b0, bout, zero}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            apply(vt[i].a, vt[i].b, vt[i].bin, vt[i].d, vt[i].bout, vt[i].zero);

        // Equal operands, then a start pulse during RUN must be ignored.
        apply(32'h12345678, 32'h12345678, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1 a = 32'h00000001; b = 32'h00000002; bin = 1'b1;
        exp_d = 32'hDEADBEEF; exp_bout = 1'b1; exp_zero = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_ready();
        repeat (2) @(negedge clk);
        chk("held_d", {32'b0, d}, 64'd0);
        chk("held_zero", {63'b0, zero}, 64'd1);
        chk("no_queued_start", 64'(q.size()), 64'd0);

        // Asynchronous reset in the middle of RUN.
        apply(32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", {63'b0, ready}, 64'd1);
        chk("mid_rst_done", {63'b0, done}, 64'd0);
        chk("mid_rst_d", {32'b0, d}, 64'd0);
        chk("mid_rst_bout_zero", {62'b0, bout, zero}, 64'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {63'b0, ready}, 64'd1);
        apply(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);

        // Random back-to-back with start held high.
        wait_ready();
        tprev = 0;
        start = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = (i % 50 == 0) ? ra : $urandom;
            rbin = 1'($urandom_range(0, 1));
            diff = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            a = ra; b = rb; bin = rbin;
            exp_d = diff[W-1:0]; exp_bout = diff[W]; exp_zero = (diff[W-1:0] == '0);
            if (i > 0) wait_ready();
            @(posedge clk);
            #1 t = cyc;
            if (i > 0) chk("spacing", 64'(t - tprev), 64'(N + 2));
            tprev = t;
        end
        start = 1'b0;

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
